// File: rtl/nclic_arbiter.sv
// NCLIC interrupt arbiter: pending/enable/priority state, winner selection,
// valid/ready offer to the core and a priority-threshold nesting stack.
module nclic_arbiter #(
    parameter int IntAmount  = 8,
    parameter int Priorities = 4,
    parameter int StackDepth = Priorities,
    localparam int IntIdWidth = $clog2(IntAmount),
    localparam int PrioWidth  = $clog2(Priorities)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IntAmount-1:0]  irq_i,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [IntIdWidth-1:0] cfg_id,
    input  logic [PrioWidth-1:0]  cfg_wdata,
    output logic                  req_valid,
    output logic [IntIdWidth-1:0] req_id,
    output logic [PrioWidth-1:0]  req_prio,
    input  logic                  req_ready,
    input  logic                  complete_i,
    output logic [PrioWidth-1:0]  cur_prio,
    output logic                  complete_err
);

    localparam int SW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
    localparam int DW = $clog2(StackDepth + 1);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SETTLE
    } state_e;

    state_e                state_q, state_d;
    logic [IntAmount-1:0]  irq_prev_q;
    logic [IntAmount-1:0]  pend_q, pend_d;
    logic [IntAmount-1:0]  en_q;
    logic [PrioWidth-1:0]  prio_q [IntAmount];
    logic [PrioWidth-1:0]  stack_q [StackDepth];
    logic [DW-1:0]         depth_q, depth_d;
    logic [PrioWidth-1:0]  cur_prio_q, cur_prio_d;
    logic                  req_valid_q, req_valid_d;
    logic [IntIdWidth-1:0] req_id_q, req_id_d;
    logic [PrioWidth-1:0]  req_prio_q, req_prio_d;
    logic                  cerr_q, cerr_d;

    logic [IntAmount-1:0]  elig;
    logic                  win_vld;
    logic [IntIdWidth-1:0] win_id;
    logic [PrioWidth-1:0]  win_prio;
    logic                  take;
    logic                  pop_ok;
    logic [SW-1:0]         top_idx;
    logic [SW-1:0]         push_idx;
    logic [DW-1:0]         base_depth;
    logic [PrioWidth-1:0]  base_cur;

    always_comb begin
        for (int i = 0; i < IntAmount; i++) begin
            elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > cur_prio_q);
        end
    end

    // Strict '>' keeps the lowest id on equal priority.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < IntAmount; i++) begin
            if (elig[i] && (prio_q[i] > win_prio)) begin
                win_vld  = 1'b1;
                win_id   = IntIdWidth'(i);
                win_prio = prio_q[i];
            end
        end
    end

    assign take = (state_q == OFFER) & req_valid_q & req_ready;

    always_comb begin
        state_d     = state_q;
        req_valid_d = 1'b0;
        req_id_d    = req_id_q;
        req_prio_d  = req_prio_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = OFFER;
                    req_valid_d = 1'b1;
                    req_id_d    = win_id;
                    req_prio_d  = win_prio;
                end
            end
            OFFER: begin
                if (take) begin
                    state_d = SETTLE;
                end else if (win_vld) begin
                    req_valid_d = 1'b1;
                    req_id_d    = win_id;
                    req_prio_d  = win_prio;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sets are applied last so an edge or set racing a clear/take wins.
    always_comb begin
        pend_d = pend_q;
        if (take) begin
            pend_d[req_id_q] = 1'b0;
        end
        if (cfg_we && (cfg_sel == 2'd3)) begin
            pend_d[cfg_id] = 1'b0;
        end
        if (cfg_we && (cfg_sel == 2'd2)) begin
            pend_d[cfg_id] = 1'b1;
        end
        pend_d = pend_d | (irq_i & ~irq_prev_q);
    end

    // Pop is resolved before push when both happen in one cycle.
    always_comb begin
        pop_ok     = complete_i & (depth_q != '0);
        cerr_d     = complete_i & (depth_q == '0);
        top_idx    = SW'(depth_q - DW'(1));
        base_depth = pop_ok ? (depth_q - DW'(1)) : depth_q;
        base_cur   = pop_ok ? stack_q[top_idx] : cur_prio_q;
        push_idx   = SW'(base_depth);
        depth_d    = take ? (base_depth + DW'(1)) : base_depth;
        cur_prio_d = take ? req_prio_q : base_cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            irq_prev_q  <= '0;
            pend_q      <= '0;
            en_q        <= '0;
            depth_q     <= '0;
            cur_prio_q  <= '0;
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            req_prio_q  <= '0;
            cerr_q      <= 1'b0;
            for (int i = 0; i < IntAmount; i++) begin
                prio_q[i] <= '0;
            end
            for (int i = 0; i < StackDepth; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            irq_prev_q  <= irq_i;
            pend_q      <= pend_d;
            depth_q     <= depth_d;
            cur_prio_q  <= cur_prio_d;
            req_valid_q <= req_valid_d;
            req_id_q    <= req_id_d;
            req_prio_q  <= req_prio_d;
            cerr_q      <= cerr_d;
            if (take) begin
                stack_q[push_idx] <= base_cur;
            end
            if (cfg_we) begin
                unique case (cfg_sel)
                    2'd0: prio_q[cfg_id] <= cfg_wdata;
                    2'd1: en_q[cfg_id]   <= cfg_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    // Only strictly higher priorities are taken, so depth is bounded.
    stack_ovf_a: assert property (
        @(posedge clk) disable iff (reset)
        take |-> (base_depth < DW'(StackDepth))
    );

    assign req_valid    = req_valid_q;
    assign req_id       = req_id_q;
    assign req_prio     = req_prio_q;
    assign cur_prio     = cur_prio_q;
    assign complete_err = cerr_q;

endmodule

// File: tb/tb_nclic_arbiter.sv
// Directed bench for nclic_arbiter: offer latency, tie-break, nesting,
// withdrawal, same-cycle edge/take and reset mid-nesting.
module tb_nclic_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_i;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [2:0] cfg_id;
    logic [1:0] cfg_wdata;
    logic       req_valid;
    logic [2:0] req_id;
    logic [1:0] req_prio;
    logic       req_ready;
    logic       complete_i;
    logic [1:0] cur_prio;
    logic       complete_err;

    int n_run  = 0;
    int n_fail = 0;

    nclic_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .irq_i        (irq_i),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_id       (cfg_id),
        .cfg_wdata    (cfg_wdata),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_prio     (req_prio),
        .req_ready    (req_ready),
        .complete_i   (complete_i),
        .cur_prio     (cur_prio),
        .complete_err (complete_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [2:0] id,
                       input logic [1:0] d);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_id    = id;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic take();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic complete();
        complete_i = 1'b1;
        tick();
        complete_i = 1'b0;
    endtask

    int pr [8] = '{3, 3, 2, 1, 3, 0, 2, 3};
    int en [8] = '{1, 0, 0, 1, 1, 0, 1, 0};

    initial begin
        reset      = 1'b1;
        irq_i      = '0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_id     = '0;
        cfg_wdata  = '0;
        req_ready  = 1'b0;
        complete_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", req_valid, 0);
        check("rst_id", req_id, 0);
        check("rst_prio", req_prio, 0);
        check("rst_cur", cur_prio, 0);
        check("rst_err", complete_err, 0);

        for (int i = 0; i < 8; i++) cfg(2'd0, 3'(i), 2'(pr[i]));
        for (int i = 0; i < 8; i++) cfg(2'd1, 3'(i), 2'(en[i]));
        check("cfg_idle", req_valid, 0);

        // edge on 1,2,4,6: id4 wins (id1/id2 disabled, id6 lower prio)
        irq_i = 8'b0101_0110;
        tick();
        check("lat_n1", req_valid, 0);
        tick();
        irq_i = '0;
        check("lat_n2", req_valid, 1);
        check("t1_id", req_id, 4);
        check("t1_prio", req_prio, 3);
        take();
        check("t1_settle", req_valid, 0);
        check("t1_cur", cur_prio, 3);
        tick();
        tick();
        check("t1_masked", req_valid, 0);
        complete();
        check("t1_pop", cur_prio, 0);
        check("t1_noerr", complete_err, 0);
        tick();
        check("n_valid6", req_valid, 1);
        check("n_id6", req_id, 6);
        check("n_prio6", req_prio, 2);

        // nesting: take id6, then id0 preempts
        take();
        check("n_cur2", cur_prio, 2);
        cfg(2'd2, 3'd0, 2'd0);
        tick();
        check("n_valid0", req_valid, 1);
        check("n_id0", req_id, 0);
        check("n_prio0", req_prio, 3);
        take();
        check("n_cur3", cur_prio, 3);
        complete();
        check("n_pop1", cur_prio, 2);
        check("n_pop1_err", complete_err, 0);
        complete();
        check("n_pop2", cur_prio, 0);
        complete();
        check("n_err", complete_err, 1);
        check("n_err_cur", cur_prio, 0);
        tick();
        check("n_err_pulse", complete_err, 0);

        // tie between id0 and id4 at prio 3
        cfg(2'd2, 3'd0, 2'd0);
        cfg(2'd2, 3'd4, 2'd0);
        tick();
        check("tie_valid", req_valid, 1);
        check("tie_id", req_id, 0);
        take();
        check("tie_settle", req_valid, 0);
        check("tie_cur", cur_prio, 3);
        tick();
        tick();
        tick();
        check("tie_block4", req_valid, 0);
        complete();
        check("tie_pop", cur_prio, 0);
        tick();
        check("tie_valid4", req_valid, 1);
        check("tie_id4", req_id, 4);

        // withdrawal: clear pending of offered id4
        cfg(2'd3, 3'd4, 2'd0);
        tick();
        check("wd_drop", req_valid, 0);
        tick();
        check("wd_idle", req_valid, 0);

        // edge on id4 in the same cycle as its take
        cfg(2'd2, 3'd4, 2'd0);
        tick();
        check("sim_valid", req_valid, 1);
        check("sim_id", req_id, 4);
        irq_i = 8'h10;
        take();
        check("sim_cur", cur_prio, 3);
        tick();
        tick();
        tick();
        check("sim_block", req_valid, 0);
        complete();
        check("sim_pop", cur_prio, 0);
        tick();
        check("sim_revalid", req_valid, 1);
        check("sim_reid", req_id, 4);

        // build cur_prio=2 with id0 offered, then reset
        cfg(2'd1, 3'd4, 2'd0);
        tick();
        check("rs_dis4", req_valid, 0);
        cfg(2'd2, 3'd6, 2'd0);
        tick();
        check("rs_id6", req_id, 6);
        take();
        cfg(2'd2, 3'd0, 2'd0);
        tick();
        check("rs_pre_valid", req_valid, 1);
        check("rs_pre_cur", cur_prio, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_valid", req_valid, 0);
        check("rs_id", req_id, 0);
        check("rs_prio", req_prio, 0);
        check("rs_cur", cur_prio, 0);
        check("rs_err", complete_err, 0);
        tick();
        tick();
        check("rs_quiet", req_valid, 0);
        complete();
        check("rs_empty", complete_err, 1);
        check("rs_empty_cur", cur_prio, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/nclic_arbiter.md
Name: nclic_arbiter

Overview:
Interrupt arbiter and nesting controller for the NCLIC. It latches interrupt requests, holds the per-source enable/priority configuration, and selects the winning source with the combinational priority tree. It offers that source to the core over a valid/ready handshake and tracks preemption nesting with a priority-threshold stack, popped on interrupt completion.

Parameters:
IntAmount, 8, number of interrupt sources; IntIdWidth = $clog2(IntAmount)
Priorities, 4, number of priority levels; PrioWidth = $clog2(Priorities); level 0 = never taken
StackDepth, Priorities, threshold stack entries

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq_i  in  IntAmount  raw interrupt lines; rising edge sets pending
cfg_we  in  1  config write strobe
cfg_sel  in  2  0=set prio, 1=set enable, 2=set pending, 3=clear pending
cfg_id  in  IntIdWidth  target source
cfg_wdata  in  PrioWidth  priority value (sel 0) or bit 0 = enable (sel 1)
req_valid  out  1  interrupt offered to core
req_id  out  IntIdWidth  offered source id
req_prio  out  PrioWidth  offered priority
req_ready  in  1  core accepts offer (take)
complete_i  in  1  core finished current handler (one-cycle pulse)
cur_prio  out  PrioWidth  current running threshold
complete_err  out  1  one-cycle pulse: complete_i with empty stack

Behaviour:
- Reset (synchronous, active-high): all pending=0, enable=0, prio=0, irq edge-detect regs=0, stack empty, cur_prio=0, FSM=IDLE, req_valid=0, req_id=0, req_prio=0, complete_err=0.
- Pending: set on a registered rising edge of irq_i[i] (irq_prev captured each cycle) or cfg sel 2; cleared on cfg sel 3 or a take of i. Same-cycle set and clear/take of the same id: set wins (pending=1 next cycle).
- Candidate: source i is eligible if pending & enable & prio[i] > cur_prio. Tree selects highest prio; ties go to lowest id.
- FSM states:
  - IDLE: if any eligible -> OFFER; register winner into req_id/req_prio and assert req_valid (latency: edge on irq_i at cycle N, pending at N+1, req_valid at N+2).
  - OFFER: req_valid=1. Payload re-registers each cycle to the current winner (may switch to a higher-prio source). If no eligible source remains (cleared/disabled/threshold raised) -> IDLE, valid drops next cycle. On req_valid & req_ready -> take, then SETTLE.
  - SETTLE: req_valid=0 for exactly one cycle so the cleared pending and the new threshold propagate -> IDLE.
- Take: clear pending[req_id]; push cur_prio; cur_prio <= req_prio. Only strictly higher priorities are taken, so the stack cannot overflow; the depth check is an assertion, not logic.
- complete_i: pop into cur_prio. With an empty stack, cur_prio is unchanged and complete_err pulses. complete_i and a take in the same cycle: the pop is applied first, then the push (net: cur_prio=req_prio, depth unchanged).
- Config writes take effect next cycle. Changing the prio or enable of the offered id re-evaluates the winner on the following cycle.
- Reset mid-offer or mid-nesting: everything returns to reset values; no take is reported.

Test Plan:
- Reset, prio={3,3,2,1,3,0,2,3}, enable={1,0,0,1,1,0,1,0}, pulse irq_i[1],[2],[4],[6] -> req_valid 2 cycles after edge, req_id=4, req_prio=3 (id1 disabled; id4 beats id6 by prio).
- Tie: enable ids 0 and 4 (both prio 3), pend both -> req_id=0. Take -> cur_prio=3, req_valid=0 in SETTLE. id4 is not offered (3 > 3 false) until complete_i -> cur_prio=0, then id4 offered.
- Nesting: take id6 (prio 2), then pend id0 (prio 3) -> offered and taken, stack depth 2. Two complete_i -> cur_prio 2 then 0. Third complete_i -> complete_err pulse, cur_prio=0.
- Withdrawal: while OFFER on id4 with req_ready=0, cfg clear pending id4 -> req_valid=0 next cycle, FSM=IDLE.
- Simultaneous: irq_i[4] rising edge in the same cycle as the take of id4 -> pending[4]=1 after take; re-offered after complete_i.
- Reset asserted while cur_prio=2 and req_valid=1 -> next cycle all outputs 0, stack empty.
